// File: rtl/dec74138_rr_arbiter.sv
`default_nettype none
// dec74138_rr_arbiter: round-robin owner of a shared 74138-style decoder with guard gap and hold limit.
// Rev 1.0
module dec74138_rr_arbiter #(
  parameter int GUARD_CYCLES = 1,
  parameter int MAX_HOLD     = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] req_i,
  output logic [7:0] gnt_o,
  output logic       select_a_o,
  output logic       select_b_o,
  output logic       select_c_o,
  output logic       g1_en_o,
  output logic       g2a_en_n_o,
  output logic       g2b_en_n_o,
  output logic [2:0] owner_o,
  output logic       busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  localparam bit         HOLD_LIMITED = (MAX_HOLD != 0);
  localparam bit         HAS_GUARD    = (GUARD_CYCLES != 0);
  localparam logic [7:0] HOLD_LIMIT   = 8'(MAX_HOLD);
  localparam logic [3:0] GUARD_LAST   = 4'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);

  logic [1:0] state;
  logic [2:0] ptr;
  logic [2:0] owner;
  logic [7:0] gnt;
  logic [7:0] hold_cnt;
  logic [3:0] guard_cnt;
  logic       g1_en;
  logic       g2a_en_n;
  logic       g2b_en_n;
  logic       busy;

  logic [2:0] pick;
  logic       any_req;
  logic       owner_req;
  logic       hold_expired;
  logic       release_grant;

  // Scan from the highest offset down so the nearest requester after ptr wins.
  always_comb begin
    pick = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (req_i[ptr + 3'(i)]) begin
        pick = ptr + 3'(i);
      end
    end
  end

  always_comb begin
    any_req       = |req_i;
    owner_req     = req_i[owner];
    hold_expired  = HOLD_LIMITED && (hold_cnt == HOLD_LIMIT);
    release_grant = !owner_req || hold_expired;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      ptr       <= 3'd0;
      owner     <= 3'd0;
      gnt       <= 8'd0;
      hold_cnt  <= 8'd0;
      guard_cnt <= 4'd0;
      g1_en     <= 1'b0;
      g2a_en_n  <= 1'b1;
      g2b_en_n  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state    <= ST_GRANT;
            owner    <= pick;
            gnt      <= 8'd1 << pick;
            hold_cnt <= 8'd1;
            g1_en    <= 1'b1;
            g2a_en_n <= 1'b0;
            g2b_en_n <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (release_grant) begin
            // Owner index stays on the selects so owner_o reports the last owner.
            state     <= HAS_GUARD ? ST_GUARD : ST_IDLE;
            ptr       <= owner + 3'd1;
            gnt       <= 8'd0;
            guard_cnt <= 4'd0;
            g1_en     <= 1'b0;
            g2a_en_n  <= 1'b1;
            g2b_en_n  <= 1'b1;
            busy      <= 1'b0;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ST_GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            state     <= ST_IDLE;
            guard_cnt <= 4'd0;
          end else begin
            guard_cnt <= guard_cnt + 4'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          gnt      <= 8'd0;
          g1_en    <= 1'b0;
          g2a_en_n <= 1'b1;
          g2b_en_n <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o      = gnt;
  assign select_a_o = owner[0];
  assign select_b_o = owner[1];
  assign select_c_o = owner[2];
  assign g1_en_o    = g1_en;
  assign g2a_en_n_o = g2a_en_n;
  assign g2b_en_n_o = g2b_en_n;
  assign owner_o    = owner;
  assign busy_o     = busy;

endmodule
`default_nettype wire

// File: tb/tb_dec74138_rr_arbiter.sv
`default_nettype none
// tb_dec74138_rr_arbiter: scoreboard bench; dut A has MAX_HOLD=4, dut B unlimited hold, both GUARD_CYCLES=1.
// Rev 1.0
module tb_dec74138_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_a = 8'd0;
  logic [7:0] req_b = 8'd0;

  logic [7:0] gnt_a, gnt_b;
  logic       sa_a, sb_a, sc_a, g1_a, g2a_a, g2b_a, busy_a;
  logic       sa_b, sb_b, sc_b, g1_b, g2a_b, g2b_b, busy_b;
  logic [2:0] own_a, own_b;

  always #5 clk = ~clk;

  dec74138_rr_arbiter #(.GUARD_CYCLES(1), .MAX_HOLD(4)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_a), .gnt_o(gnt_a),
    .select_a_o(sa_a), .select_b_o(sb_a), .select_c_o(sc_a),
    .g1_en_o(g1_a), .g2a_en_n_o(g2a_a), .g2b_en_n_o(g2b_a),
    .owner_o(own_a), .busy_o(busy_a)
  );

  dec74138_rr_arbiter #(.GUARD_CYCLES(1), .MAX_HOLD(0)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_b), .gnt_o(gnt_b),
    .select_a_o(sa_b), .select_b_o(sb_b), .select_c_o(sc_b),
    .g1_en_o(g1_b), .g2a_en_n_o(g2a_b), .g2b_en_n_o(g2b_b),
    .owner_o(own_b), .busy_o(busy_b)
  );

  typedef struct {
    logic [2:0] owner;
    logic [7:0] gnt;
    int         len;
    int         gap;   // 0: gap before this grant is not checked
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic push(input int d, input logic [2:0] o, input logic [7:0] g, input int len, input int gap);
    exp_t e;
    e.owner = o; e.gnt = g; e.len = len; e.gap = gap;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // Monitor: tracks each grant window per dut and scores it against the queue when it closes.
  bit         m_prev[2];
  int         m_len[2], m_idle[2], m_gap[2];
  logic [7:0] m_gnt[2];
  logic [2:0] m_own[2], m_sel[2];
  bit         m_en_ok[2], m_stable[2];

  always @(negedge clk) begin
    logic [7:0] g;
    logic [2:0] o, s;
    logic       b, e1, e2a, e2b, inv_ok;
    exp_t       e;
    int         qs;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        g = gnt_a; o = own_a; s = {sc_a, sb_a, sa_a}; b = busy_a; e1 = g1_a; e2a = g2a_a; e2b = g2b_a;
      end else begin
        g = gnt_b; o = own_b; s = {sc_b, sb_b, sa_b}; b = busy_b; e1 = g1_b; e2a = g2a_b; e2b = g2b_b;
      end
      inv_ok = (e1 == b) && (e2a == !b) && (e2b == !b) && ((g != 8'd0) == b) &&
               (s == o) && ((g == 8'd0) || (g == (8'd1 << o)));
      check($sformatf("d%0d_invariant", d), 32'(inv_ok), 32'd1);
      if (b && !m_prev[d]) begin
        m_gnt[d] = g; m_own[d] = o; m_sel[d] = s; m_len[d] = 1; m_gap[d] = m_idle[d];
        m_en_ok[d] = e1 && !e2a && !e2b; m_stable[d] = 1'b1;
      end else if (b && m_prev[d]) begin
        m_len[d]++;
        if (g != m_gnt[d]) m_stable[d] = 1'b0;
      end else if (!b && m_prev[d]) begin
        qs = (d == 0) ? q_a.size() : q_b.size();
        check($sformatf("d%0d_grant_expected", d), 32'(qs != 0), 32'd1);
        if (qs != 0) begin
          if (d == 0) e = q_a.pop_front();
          else        e = q_b.pop_front();
          check($sformatf("d%0d_owner", d), 32'(m_own[d]), 32'(e.owner));
          check($sformatf("d%0d_gnt", d), 32'(m_gnt[d]), 32'(e.gnt));
          check($sformatf("d%0d_select", d), 32'(m_sel[d]), 32'(e.owner));
          check($sformatf("d%0d_enables", d), 32'(m_en_ok[d]), 32'd1);
          check($sformatf("d%0d_len", d), 32'(m_len[d]), 32'(e.len));
          check($sformatf("d%0d_stable", d), 32'(m_stable[d]), 32'd1);
          if (e.gap != 0) check($sformatf("d%0d_gap", d), 32'(m_gap[d]), 32'(e.gap));
        end
        m_idle[d] = 1;
      end else begin
        m_idle[d]++;
      end
      m_prev[d] = b;
    end
  end

  initial begin
    bit idle_bad;

    // Reset held with every request high
    rst_n = 1'b0; req_a = 8'hFF; req_b = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_gnt_a", 32'(gnt_a), 32'h00);
    check("rst_g1_a", 32'(g1_a), 32'd0);
    check("rst_g2a_a", 32'(g2a_a), 32'd1);
    check("rst_g2b_a", 32'(g2b_a), 32'd1);
    check("rst_owner_a", 32'(own_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_gnt_b", 32'(gnt_b), 32'h00);
    rst_n = 1'b1; req_a = 8'h00; req_b = 8'h00;
    idle_bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a || busy_b) idle_bad = 1'b1;
    end
    check("idle_after_reset", 32'(idle_bad), 32'd0);

    // B: single request of 5 cycles, then owner 0 held 301 cycles against requester 5
    push(1, 3'd3, 8'h08, 5, 0);
    req_b = 8'h08;
    repeat (5) @(negedge clk);
    push(1, 3'd0, 8'h01, 301, 2);
    req_b = 8'h01;
    repeat (3) @(negedge clk);
    req_b = 8'h21;
    repeat (300) @(negedge clk);
    push(1, 3'd5, 8'h20, 3, 2);
    req_b = 8'h20;
    repeat (5) @(negedge clk);
    req_b = 8'h00;
    repeat (5) @(negedge clk);

    // A: all requesting, hold limit 4 forces 0..7,0 rotation with 2-cycle gaps
    for (int g = 0; g < 9; g++) push(0, 3'(g % 8), 8'd1 << (g % 8), 4, (g == 0) ? 0 : 2);
    req_a = 8'hFF;
    repeat (53) @(negedge clk);
    req_a = 8'h00;
    repeat (5) @(negedge clk);

    // A: owner 6 force-released (ptr=7); with 0x41 the next owner is 0, not 6
    push(0, 3'd6, 8'h40, 4, 0);
    push(0, 3'd0, 8'h01, 4, 2);
    req_a = 8'h40;
    @(negedge clk);
    req_a = 8'h41;
    repeat (10) @(negedge clk);
    req_a = 8'h00;
    repeat (5) @(negedge clk);

    // Async reset between edges while both duts are granting
    push(0, 3'd2, 8'h04, 2, 0);
    push(1, 3'd4, 8'h10, 2, 0);
    req_a = 8'h04; req_b = 8'h10;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_gnt_a", 32'(gnt_a), 32'h00);
    check("async_g1_a", 32'(g1_a), 32'd0);
    check("async_g2a_a", 32'(g2a_a), 32'd1);
    check("async_g2b_a", 32'(g2b_a), 32'd1);
    check("async_busy_a", 32'(busy_a), 32'd0);
    check("async_gnt_b", 32'(gnt_b), 32'h00);
    check("async_g1_b", 32'(g1_b), 32'd0);

    // Pointer restarts at 0: 0x82 picks 1 (not 7), 0x81 picks 0 (not 7)
    req_a = 8'h82; req_b = 8'h81;
    push(0, 3'd1, 8'h02, 1, 0);
    push(1, 3'd0, 8'h01, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_a = 8'h00; req_b = 8'h00;
    repeat (6) @(negedge clk);

    check("q_a_drained", 32'(q_a.size()), 32'd0);
    check("q_b_drained", 32'(q_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
